// File: rtl/gemm_pkg.sv
// Shared state encoding, default widths and the chunk-word type for the GEMM PE feeder.
package gemm_pkg;

  localparam int IN_DATA_W  = 8;
  localparam int NUM_INPUTS = 4;
  localparam int OUT_DATA_W = 32;

  typedef logic [NUM_INPUTS*IN_DATA_W-1:0] chunk_word_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    TAIL,
    RESULT,
    CLEAR
  } feeder_state_e;

endpackage

// File: rtl/gemm_pe_feeder_if.sv
// Result valid/ready channel from the feeder (master) to its consumer (slave).
interface gemm_pe_feeder_if
  import gemm_pkg::*;
#(
  parameter int OutDataWidth = OUT_DATA_W
);

  logic                    res_valid_o;
  logic                    res_ready_i;
  logic [OutDataWidth-1:0] res_data_o;

  modport master (output res_valid_o, output res_data_o, input res_ready_i);
  modport slave  (input res_valid_o, input res_data_o, output res_ready_i);

endinterface

// File: rtl/gemm_feeder_addr_gen.sv
// Chunk index counter with base+index operand addresses and first/last-chunk flags.
module gemm_feeder_addr_gen #(
  parameter int AddrWidth = 16,
  parameter int KWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [KWidth-1:0]    k_chunks_i,
  input  logic [AddrWidth-1:0] a_base_i,
  input  logic [AddrWidth-1:0] b_base_i,
  output logic [AddrWidth-1:0] a_addr_o,
  output logic [AddrWidth-1:0] b_addr_o,
  output logic                 first_o,
  output logic                 last_o
);

  logic [KWidth-1:0]    idx_q, idx_d;
  logic [AddrWidth-1:0] idx_ext;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + KWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // The index tops out at K, which fits because K is itself a KWidth value.
  assign idx_ext  = AddrWidth'(idx_q);
  assign a_addr_o = a_base_i + idx_ext;
  assign b_addr_o = b_base_i + idx_ext;
  assign first_o  = (idx_q == '0);
  assign last_o   = (idx_q == k_chunks_i - KWidth'(1));

endmodule

// File: rtl/gemm_pe_feeder.sv
// Streams K operand chunks into one output-stationary MAC PE, then drains its result.
// Optional GEMM_FEEDER_PERF_CNT_EN adds a saturating busy-cycle counter (perf_cycles_o).
module gemm_pe_feeder
  import gemm_pkg::*;
#(
  parameter int InDataWidth  = IN_DATA_W,
  parameter int NumInputs    = NUM_INPUTS,
  parameter int OutDataWidth = OUT_DATA_W,
  parameter int AddrWidth    = 16,
  parameter int KWidth       = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [KWidth-1:0]                k_chunks_i,
  input  logic [AddrWidth-1:0]             a_base_i,
  input  logic [AddrWidth-1:0]             b_base_i,
  output logic                             busy_o,
  output logic                             a_req_o,
  output logic [AddrWidth-1:0]             a_addr_o,
  input  logic [NumInputs*InDataWidth-1:0] a_rdata_i,
  output logic                             b_req_o,
  output logic [AddrWidth-1:0]             b_addr_o,
  input  logic [NumInputs*InDataWidth-1:0] b_rdata_i,
  output logic [NumInputs*InDataWidth-1:0] pe_a_o,
  output logic [NumInputs*InDataWidth-1:0] pe_b_o,
  output logic                             pe_a_valid_o,
  output logic                             pe_b_valid_o,
  output logic                             pe_init_save_o,
  output logic                             pe_acc_clr_o,
  input  logic [OutDataWidth-1:0]          pe_c_i,
  gemm_pe_feeder_if.master                 res_if,
  output logic                             done_o
`ifdef GEMM_FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_cycles_o
`endif
);

  feeder_state_e        state_q, state_d;
  logic [KWidth-1:0]    k_q, k_d;
  logic [AddrWidth-1:0] a_base_q, a_base_d;
  logic [AddrWidth-1:0] b_base_q, b_base_d;
  logic                 zero_q, zero_d;
  logic                 pipe_valid_q, pipe_valid_d;
  logic                 init_q, init_d;

  logic                 start_acc;
  logic                 run;
  logic [AddrWidth-1:0] gen_a_addr, gen_b_addr;
  logic                 idx_first, idx_last;

  assign start_acc = (state_q == IDLE) && start_i;
  assign run       = (state_q == RUN);

  gemm_feeder_addr_gen #(
    .AddrWidth (AddrWidth),
    .KWidth    (KWidth)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (start_acc),
    .inc_i      (run),
    .k_chunks_i (k_q),
    .a_base_i   (a_base_q),
    .b_base_i   (b_base_q),
    .a_addr_o   (gen_a_addr),
    .b_addr_o   (gen_b_addr),
    .first_o    (idx_first),
    .last_o     (idx_last)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    a_base_d     = a_base_q;
    b_base_d     = b_base_q;
    zero_d       = zero_q;
    pipe_valid_d = run;
    init_d       = run && idx_first;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          k_d      = k_chunks_i;
          a_base_d = a_base_i;
          b_base_d = b_base_i;
          zero_d   = (k_chunks_i == '0);
          state_d  = (k_chunks_i == '0) ? RESULT : RUN;
        end
      end
      RUN:    if (idx_last) state_d = TAIL;
      TAIL:   state_d = RESULT;
      RESULT: if (res_if.res_ready_i) state_d = CLEAR;
      CLEAR: begin
        zero_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      k_q          <= '0;
      a_base_q     <= '0;
      b_base_q     <= '0;
      zero_q       <= 1'b0;
      pipe_valid_q <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_base_q     <= a_base_d;
      b_base_q     <= b_base_d;
      zero_q       <= zero_d;
      pipe_valid_q <= pipe_valid_d;
      init_q       <= init_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign a_req_o  = run;
  assign b_req_o  = run;
  assign a_addr_o = run ? gen_a_addr : '0;
  assign b_addr_o = run ? gen_b_addr : '0;

  // Memory data arrives one cycle after the request, aligned with pipe_valid_q.
  assign pe_a_o         = pipe_valid_q ? a_rdata_i : '0;
  assign pe_b_o         = pipe_valid_q ? b_rdata_i : '0;
  assign pe_a_valid_o   = pipe_valid_q;
  assign pe_b_valid_o   = pipe_valid_q;
  assign pe_init_save_o = init_q;
  assign pe_acc_clr_o   = (state_q == CLEAR);
  assign done_o         = (state_q == CLEAR);

  // No PE strobes fire in RESULT, so pe_c_i holds steady for the whole handshake.
  assign res_if.res_valid_o = (state_q == RESULT);
  assign res_if.res_data_o  = ((state_q == RESULT) && !zero_q) ? pe_c_i : '0;

`ifdef GEMM_FEEDER_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (busy_o && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_gemm_pe_feeder.sv
// Directed bench for gemm_pe_feeder with operand-memory and MAC PE models.
module tb_gemm_pe_feeder;
  import gemm_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [15:0]       k_chunks_i;
  logic [15:0]       a_base_i, b_base_i;
  logic              busy_o;
  logic              a_req_o, b_req_o;
  logic [15:0]       a_addr_o, b_addr_o;
  chunk_word_t       a_rdata_i, b_rdata_i;
  chunk_word_t       pe_a_o, pe_b_o;
  logic              pe_a_valid_o, pe_b_valid_o;
  logic              pe_init_save_o, pe_acc_clr_o;
  logic [31:0]       pe_c_i;
  logic              done_o;
`ifdef GEMM_FEEDER_PERF_CNT_EN
  logic [31:0]       perf_cycles_o;
`endif

  logic              pe_load;
  logic [31:0]       pe_load_val;
  int                n_tests = 0;
  int                n_fail  = 0;

  gemm_pe_feeder_if res_if ();

  gemm_pe_feeder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .k_chunks_i     (k_chunks_i),
    .a_base_i       (a_base_i),
    .b_base_i       (b_base_i),
    .busy_o         (busy_o),
    .a_req_o        (a_req_o),
    .a_addr_o       (a_addr_o),
    .a_rdata_i      (a_rdata_i),
    .b_req_o        (b_req_o),
    .b_addr_o       (b_addr_o),
    .b_rdata_i      (b_rdata_i),
    .pe_a_o         (pe_a_o),
    .pe_b_o         (pe_b_o),
    .pe_a_valid_o   (pe_a_valid_o),
    .pe_b_valid_o   (pe_b_valid_o),
    .pe_init_save_o (pe_init_save_o),
    .pe_acc_clr_o   (pe_acc_clr_o),
    .pe_c_i         (pe_c_i),
    .res_if         (res_if),
    .done_o         (done_o)
`ifdef GEMM_FEEDER_PERF_CNT_EN
    ,
    .perf_cycles_o  (perf_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic chunk_word_t a_word(input logic [15:0] addr);
    return {addr[7:0] + 8'd1, addr[7:0] + 8'd2, addr[15:8], addr[7:0] ^ 8'h3C};
  endfunction

  function automatic chunk_word_t b_word(input logic [15:0] addr);
    return {addr[7:0], 8'd3, addr[7:0] ^ 8'h55, addr[15:8] + 8'd7};
  endfunction

  function automatic logic [31:0] dot(input chunk_word_t a, input chunk_word_t b);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) s = s + 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
    return s;
  endfunction

  // Operand memories: data one cycle after the request, garbage otherwise.
  always @(posedge clk_i) begin
    a_rdata_i <= a_req_o ? a_word(a_addr_o) : 32'hDEAD_BEEF;
    b_rdata_i <= b_req_o ? b_word(b_addr_o) : 32'hCAFE_F00D;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              pe_c_i <= '0;
    else if (pe_load)                         pe_c_i <= pe_load_val;
    else if (pe_acc_clr_o)                    pe_c_i <= '0;
    else if (pe_init_save_o)                  pe_c_i <= dot(pe_a_o, pe_b_o);
    else if (pe_a_valid_o && pe_b_valid_o)    pe_c_i <= pe_c_i + dot(pe_a_o, pe_b_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called at the drive point of cycle 0; returns at the drive point of an idle cycle.
  task automatic job(input int k, input logic [15:0] ab, input logic [15:0] bb, input int stall);
    logic [31:0] exp_res;
    logic [15:0] ea, eb;
    exp_res = '0;
    for (int i = 0; i < k; i++) exp_res = exp_res + dot(a_word(ab + 16'(i)), b_word(bb + 16'(i)));
    start_i = 1'b1; k_chunks_i = 16'(k); a_base_i = ab; b_base_i = bb;
    res_if.res_ready_i = (stall == 0);
    @(negedge clk_i);
    chk("c0_busy", 64'(busy_o), 64'd0);
    tick();
    start_i = 1'b0;
    if (k > 0) begin
      for (int c = 1; c <= k + 1; c++) begin
        @(negedge clk_i);
        ea = (c <= k) ? ab + 16'(c - 1) : 16'h0;
        eb = (c <= k) ? bb + 16'(c - 1) : 16'h0;
        chk("run_busy", 64'(busy_o), 64'd1);
        chk("a_req", 64'(a_req_o), 64'(c <= k));
        chk("b_req", 64'(b_req_o), 64'(c <= k));
        chk("a_addr", 64'(a_addr_o), 64'(ea));
        chk("b_addr", 64'(b_addr_o), 64'(eb));
        chk("pe_valid", 64'({pe_a_valid_o, pe_b_valid_o}), (c >= 2) ? 64'd3 : 64'd0);
        chk("init_save", 64'(pe_init_save_o), 64'(c == 2));
        chk("pe_a", 64'(pe_a_o), (c >= 2) ? 64'(a_word(ab + 16'(c - 2))) : 64'd0);
        chk("pe_b", 64'(pe_b_o), (c >= 2) ? 64'(b_word(bb + 16'(c - 2))) : 64'd0);
        chk("early_res_valid", 64'(res_if.res_valid_o), 64'd0);
        tick();
      end
    end
    @(negedge clk_i);
    chk("res_valid", 64'(res_if.res_valid_o), 64'd1);
    chk("res_data", 64'(res_if.res_data_o), 64'(exp_res));
    chk("res_strobes", 64'({pe_a_valid_o, pe_init_save_o, pe_acc_clr_o, a_req_o}), 64'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      start_i = (s % 2 == 0);
      k_chunks_i = 16'd5;
      @(negedge clk_i);
      chk("stall_valid", 64'(res_if.res_valid_o), 64'd1);
      chk("stall_data", 64'(res_if.res_data_o), 64'(exp_res));
      chk("stall_strobes", 64'({pe_a_valid_o, pe_b_valid_o, pe_init_save_o, pe_acc_clr_o, a_req_o, done_o}), 64'd0);
    end
    if (stall > 0) begin
      tick();
      start_i = 1'b0;
      res_if.res_ready_i = 1'b1;
      @(negedge clk_i);
      chk("hs_valid", 64'(res_if.res_valid_o), 64'd1);
    end
    tick();
    @(negedge clk_i);
    chk("clr_pulse", 64'(pe_acc_clr_o), 64'd1);
    chk("done_pulse", 64'(done_o), 64'd1);
    chk("clr_busy", 64'(busy_o), 64'd1);
    chk("clr_quiet", 64'({res_if.res_valid_o, pe_a_valid_o, pe_init_save_o}), 64'd0);
    tick();
    @(negedge clk_i);
    chk("idle_after", 64'({busy_o, done_o, pe_acc_clr_o, res_if.res_valid_o}), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; k_chunks_i = '0; a_base_i = '0; b_base_i = '0;
    res_if.res_ready_i = 1'b0; pe_load = 1'b0; pe_load_val = '0;
    #12;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_reqs", 64'({a_req_o, b_req_o}), 64'd0);
    chk("rst_addrs", 64'({a_addr_o, b_addr_o}), 64'd0);
    chk("rst_pe", 64'({pe_a_valid_o, pe_b_valid_o, pe_init_save_o, pe_acc_clr_o}), 64'd0);
    chk("rst_pe_data", 64'({pe_a_o, pe_b_o}), 64'd0);
    chk("rst_res", 64'({res_if.res_valid_o, res_if.res_data_o, done_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    job(3, 16'h0010, 16'h0200, 0);

    pe_load = 1'b1; pe_load_val = 32'h55;
    tick();
    pe_load = 1'b0;
    job(0, 16'h0100, 16'h0300, 0);

    job(1, 16'h0020, 16'h0400, 0);
    job(2, 16'h0033, 16'h0044, 5);
    job(4, 16'hFFFE, 16'h1234, 0);

    // Reset in cycle 2 of a K=8 job.
    start_i = 1'b1; k_chunks_i = 16'd8; a_base_i = 16'h0500; b_base_i = 16'h0600;
    res_if.res_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    chk("pre_rst_valid", 64'(pe_a_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_reqs", 64'({a_req_o, b_req_o, a_addr_o, b_addr_o}), 64'd0);
    chk("arst_pe", 64'({pe_a_valid_o, pe_b_valid_o, pe_init_save_o, pe_acc_clr_o}), 64'd0);
    chk("arst_pe_data", 64'({pe_a_o, pe_b_o}), 64'd0);
    chk("arst_res", 64'({res_if.res_valid_o, done_o}), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    job(2, 16'h0040, 16'h0080, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_pe_feeder.md
Name: gemm_pe_feeder

Overview:
Operand sequencer and result drainer for one output-stationary MAC PE in the GEMM datapath. On a start command it streams K-chunks of A and B operands from two single-cycle-latency operand memories into the PE. It drives the PE valid, init-save and clear strobes, then returns the accumulated result over a valid/ready handshake.

Parameters:
InDataWidth, 8, width of one operand element
NumInputs, 4, elements per PE chunk; memory word = NumInputs*InDataWidth
OutDataWidth, 32, PE accumulator/result width
AddrWidth, 16, operand memory address width
KWidth, 16, width of the chunk-count field

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start command; sampled only in IDLE
k_chunks_i  in  KWidth  number of K-chunks to accumulate, latched on start
a_base_i  in  AddrWidth  A chunk-0 address, latched on start
b_base_i  in  AddrWidth  B chunk-0 address, latched on start
busy_o  out  1  high in every state except IDLE
a_req_o  out  1  A memory read request
a_addr_o  out  AddrWidth  A read address
a_rdata_i  in  NumInputs*InDataWidth  A read data, valid the cycle after a_req_o
b_req_o  out  1  B memory read request
b_addr_o  out  AddrWidth  B read address
b_rdata_i  in  NumInputs*InDataWidth  B read data, valid the cycle after b_req_o
pe_a_o  out  NumInputs*InDataWidth  operand A to PE
pe_b_o  out  NumInputs*InDataWidth  operand B to PE
pe_a_valid_o  out  1  PE A valid
pe_b_valid_o  out  1  PE B valid
pe_init_save_o  out  1  PE first-chunk save strobe
pe_acc_clr_o  out  1  PE accumulator clear
pe_c_i  in  OutDataWidth  PE accumulator value
res_valid_o  out  1  result valid
res_ready_i  in  1  result ready
res_data_o  out  OutDataWidth  result
done_o  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset: state IDLE. All outputs 0: busy, reqs, addrs, PE strobes, pe_a/pe_b, res_valid, res_data, done. Internal counters 0.
- Reset mid-job aborts immediately, with no clear pulse. The PE is reset by the same rst_ni.
- FSM states: IDLE, RUN, TAIL, RESULT, CLEAR.
- IDLE: when start_i=1, latch config. If k_chunks_i>0 go to RUN; if 0 go to RESULT with zero_flag set.
- RUN, one cycle per chunk idx=0..K-1:
  - a_req_o=b_req_o=1; a_addr_o=a_base+idx, b_addr_o=b_base+idx.
  - Address addition wraps modulo 2^AddrWidth.
  - After idx=K-1 go to TAIL.
- PE drive:
  - A registered pipe_valid follows the request by one cycle. pe_a_o/pe_b_o = a_rdata_i/b_rdata_i when pipe_valid, else 0.
  - pe_a_valid_o=pe_b_valid_o=pipe_valid.
  - pe_init_save_o=1 only on the chunk-0 data cycle. Valids are also high that cycle; the PE gives init_save priority.
- TAIL: presents the last chunk data, with no request. Go to RESULT.
- RESULT:
  - res_valid_o=1; res_data_o = zero_flag ? 0 : pe_c_i.
  - pe_c_i is stable here because no PE strobes are asserted.
  - Hold until res_valid_o&&res_ready_i, then go to CLEAR.
  - res_data_o must not change while res_valid_o is high.
- CLEAR: one cycle of pe_acc_clr_o=1 (valids 0), done_o=1, zero_flag cleared. Go to IDLE.
- Latency: with start sampled in cycle 0 and K>0, requests occur in cycles 1..K, PE data in cycles 2..K+1, and res_valid_o first high in cycle K+2. K=0 gives res_valid_o in cycle 1.
- start_i while busy is ignored; no queueing.
- K=1: init_save and TAIL coincide on the same data cycle.
- K=2^KWidth-1 is supported; the index counter must not overflow.

Optional Feature:
GEMM_FEEDER_PERF_CNT_EN
- Defined: adds output perf_cycles_o [31:0], counting cycles with busy_o=1.
  - Clears on an accepted start; holds after done. Saturates at all-ones.
  - Reset value 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- gemm_pkg holds:
  - feeder_state_e enum {IDLE, RUN, TAIL, RESULT, CLEAR};
  - default width localparams (IN_DATA_W=8, NUM_INPUTS=4, OUT_DATA_W=32);
  - a chunk-word typedef sized NumInputs*InDataWidth.
- One sub-module, gemm_feeder_addr_gen: chunk index counter plus the two base+idx address adders and a last-chunk flag.

Test Plan:
- K=3, a_base=0x0010, b_base=0x0200, start in cycle 0 -> requests in cycles 1-3 at A 0x10-0x12 and B 0x200-0x202; init_save only in cycle 2; valids in cycles 2-4; res_valid in cycle 5; acc_clr and done in the cycle after the handshake.
- K=0 -> no requests, no valids; res_valid in cycle 1 with res_data=0 even if the PE model holds 0x55; clear pulse after the handshake.
- K=1 -> one request in cycle 1; init_save+valids in cycle 2; res_valid in cycle 3.
- Backpressure: res_ready low for 5 cycles -> res_valid and res_data stable, no PE strobes, start_i pulses ignored; completes on ready.
- a_base=0xFFFE, K=4 -> A addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst_ni asserted in cycle 2 of a K=8 job -> all outputs 0 asynchronously; a new start after release runs a clean job with init_save on its first data cycle.
